vga_char_fetch: RTL and testbench

- Text-mode VGA fetch/serialise stage, downstream of the next-character-address calculator.
- Registers the calculator's next_char / next_y_addr outputs once per 8-pixel cell and feeds them back as its char_addr / y_addr inputs.
- Reads the character code from text VRAM, then the glyph row from the font ROM, and shifts out one pixel per clock for an 80x60 grid of 8x8 cells.
- Sits between the sync counter, the address calculator, the VRAM/font ROM ports and the DAC output register.

---
 rtl/vga_text_pkg.sv | 19 +
 rtl/vga_char_fetch_if.sv | 25 ++
 rtl/vga_pixel_shifter.sv | 32 +++
 rtl/vga_char_fetch.sv | 94 +++++++++
 tb/tb_vga_char_fetch.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/vga_text_pkg.sv
// Shared geometry for the 80x60 text-mode pipeline: sync timing anchors,
// cell size and the address widths used by VRAM and the font ROM.
package vga_text_pkg;

   localparam int unsigned FIRST_X_START = 144;
   localparam int unsigned FIRST_Y_START = 35;
   localparam int unsigned H_ACTIVE      = 640;
   localparam int unsigned V_ACTIVE      = 480;

   localparam int unsigned CHAR_W        = 8;
   localparam int unsigned CHAR_H        = 8;
   localparam int unsigned TEXT_COLS     = 80;
   localparam int unsigned TEXT_ROWS     = 60;
   localparam int unsigned FETCH_START   = 136;

   localparam int unsigned CHAR_ADDR_W   = 13;
   localparam int unsigned FONT_ADDR_W   = 11;

endpackage

// File: rtl/vga_char_fetch_if.sv
// Read bus between the fetch stage and the text VRAM / font ROM.
// Both memories are synchronous with one cycle of read latency.
interface vga_char_fetch_if;
   import vga_text_pkg::*;

   logic [CHAR_ADDR_W-1:0] vram_addr;
   logic [7:0]             vram_data;
   logic [FONT_ADDR_W-1:0] font_addr;
   logic [7:0]             font_data;

   modport master (
      output vram_addr,
      output font_addr,
      input  vram_data,
      input  font_data
   );

   modport slave (
      input  vram_addr,
      input  font_addr,
      output vram_data,
      output font_data
   );

endinterface

// File: rtl/vga_pixel_shifter.sv
// Glyph-row serialiser: loads one 8-bit row per cell, shifts MSB-first,
// and maps the current bit to RGB332 only while display enable is set.
module vga_pixel_shifter #(
   parameter logic [7:0] FG_COLOR = 8'hFF,
   parameter logic [7:0] BG_COLOR = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       load,
   input  logic [7:0] glyph,
   input  logic       de_next,
   output logic       pixel,
   output logic [7:0] rgb
);

   logic [7:0] shift_q;
   logic       de_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shift_q <= '0;
         de_q    <= 1'b0;
      end else begin
         shift_q <= load ? glyph : {shift_q[6:0], 1'b0};
         de_q    <= de_next;
      end
   end

   assign pixel = shift_q[7] & de_q;
   assign rgb   = de_q ? (shift_q[7] ? FG_COLOR : BG_COLOR) : 8'h00;

endmodule

// File: rtl/vga_char_fetch.sv
// Text-mode fetch stage: latches the calculator's next cell address once per
// cell, reads char code then glyph row, and hands the row to the serialiser.
module vga_char_fetch
   import vga_text_pkg::*;
#(
   parameter logic [7:0] FG_COLOR = 8'hFF,
   parameter logic [7:0] BG_COLOR = 8'h00
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [9:0]             h_count_i,
   input  logic [9:0]             v_count_i,
   input  logic [CHAR_ADDR_W-1:0] next_char_i,
   input  logic [2:0]             next_y_addr_i,
   output logic [CHAR_ADDR_W-1:0] char_addr_o,
   output logic [2:0]             y_addr_o,
   vga_char_fetch_if.master       mem,
   output logic                   pixel_o,
   output logic [7:0]             rgb_o
);

   localparam logic [9:0] V_FIRST    = 10'(FIRST_Y_START);
   localparam logic [9:0] V_LAST     = 10'(FIRST_Y_START + V_ACTIVE - 1);
   localparam logic [9:0] H_FETCH_LO = 10'(FETCH_START);
   localparam logic [9:0] H_FETCH_HI = 10'(FIRST_X_START + H_ACTIVE - 2 * CHAR_W);
   localparam logic [9:0] H_LOAD_LO  = 10'(FIRST_X_START - 1);
   localparam logic [9:0] H_LOAD_HI  = 10'(FIRST_X_START + H_ACTIVE - CHAR_W - 1);
   localparam logic [9:0] H_DE_LO    = 10'(FIRST_X_START - 1);
   localparam logic [9:0] H_DE_HI    = 10'(FIRST_X_START + H_ACTIVE - 2);

   logic                   v_act;
   logic                   fetch_stb;
   logic                   load_stb;
   logic                   de_next;
   logic                   armed_q;
   logic [CHAR_ADDR_W-1:0] char_addr_q;
   logic [2:0]             y_addr_q;
   logic [2:0]             stb_pipe_q;
   logic [7:0]             glyph_hold_q;

   assign v_act = (v_count_i >= V_FIRST) && (v_count_i <= V_LAST);

   // After reset nothing is fetched or displayed until a line starts cleanly
   // at the first cell strobe, so a partial line never shows stale addresses.
   assign fetch_stb = v_act && (h_count_i[2:0] == 3'd0)
                      && (h_count_i >= H_FETCH_LO) && (h_count_i <= H_FETCH_HI)
                      && (armed_q || (h_count_i == H_FETCH_LO));

   assign load_stb  = v_act && (h_count_i[2:0] == 3'd7)
                      && (h_count_i >= H_LOAD_LO) && (h_count_i <= H_LOAD_HI);

   assign de_next   = v_act && armed_q
                      && (h_count_i >= H_DE_LO) && (h_count_i <= H_DE_HI);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         armed_q      <= 1'b0;
         char_addr_q  <= '0;
         y_addr_q     <= '0;
         stb_pipe_q   <= '0;
         glyph_hold_q <= '0;
      end else begin
         armed_q    <= armed_q | fetch_stb;
         stb_pipe_q <= {stb_pipe_q[1:0], fetch_stb};
         if (fetch_stb) begin
            char_addr_q <= next_char_i;
            y_addr_q    <= next_y_addr_i;
         end
         // stb_pipe_q[2] marks the cycle the font ROM row for this cell is valid
         if (stb_pipe_q[2]) begin
            glyph_hold_q <= mem.font_data;
         end
      end
   end

   assign char_addr_o   = char_addr_q;
   assign y_addr_o      = y_addr_q;
   assign mem.vram_addr = char_addr_q;
   assign mem.font_addr = {mem.vram_data, y_addr_q};

   vga_pixel_shifter #(
      .FG_COLOR (FG_COLOR),
      .BG_COLOR (BG_COLOR)
   ) u_shifter (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load    (load_stb),
      .glyph   (glyph_hold_q),
      .de_next (de_next),
      .pixel   (pixel_o),
      .rgb     (rgb_o)
   );

endmodule

// File: tb/tb_vga_char_fetch.sv
// Randomised bench for vga_char_fetch: random VRAM/font contents, calculator
// in the loop, and a screen-coordinate reference model of every output pixel.
module tb_vga_char_fetch;

   logic        clk_i;
   logic        rst_n_i;
   logic [9:0]  h_count;
   logic [9:0]  v_count;
   logic [12:0] next_char;
   logic [2:0]  next_y;
   logic [12:0] char_addr;
   logic [2:0]  y_addr;
   logic        pixel;
   logic [7:0]  rgb;

   logic [7:0]  vram_mem [0:8191];
   logic [7:0]  font_mem [0:2047];
   logic [7:0]  vram_q;
   logic [7:0]  font_q;

   int          n_checks;
   int          n_pass;
   int          cur_h;
   int          cur_v;

   bit          armed_m;
   int          exp_char;
   int          exp_y;

   vga_char_fetch_if mem_if ();

   vga_char_fetch dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .h_count_i     (h_count),
      .v_count_i     (v_count),
      .next_char_i   (next_char),
      .next_y_addr_i (next_y),
      .char_addr_o   (char_addr),
      .y_addr_o      (y_addr),
      .mem           (mem_if),
      .pixel_o       (pixel),
      .rgb_o         (rgb)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vram_q <= '0;
         font_q <= '0;
      end else begin
         vram_q <= vram_mem[mem_if.vram_addr];
         font_q <= font_mem[mem_if.font_addr];
      end
   end

   assign mem_if.vram_data = vram_q;
   assign mem_if.font_data = font_q;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, cur_h, cur_v);
      else
         n_pass++;
   endtask

   // Glyph bit shown at screen position (h, v), straight from screen geometry.
   function automatic bit glyph_bit(input int h, input int v);
      int x, t, ch;
      logic [7:0] code;
      logic [7:0] row;
      x    = h - 144;
      t    = v - 35;
      ch   = (t / 8) * 80 + x / 8;
      code = vram_mem[ch];
      row  = font_mem[int'(code) * 8 + t % 8];
      return row[7 - x % 8];
   endfunction

   task automatic run_line(input int v, input int rst_from, input int rst_to);
      for (int h = 0; h < 800; h++) begin
         bit in_rst, v_act, h_act, stb, show, exp_pix;
         int t;
         logic [7:0] exp_rgb;
         @(posedge clk_i);
         #1;
         cur_h   = h;
         cur_v   = v;
         in_rst  = (h >= rst_from) && (h <= rst_to);
         rst_n_i = !in_rst;
         h_count = 10'(h);
         v_count = 10'(v);
         t       = v - 35;
         v_act   = (v >= 35) && (v <= 514);
         stb     = v_act && (h % 8 == 0) && (h >= 136) && (h <= 768);
         if (stb && h == 136) begin
            next_char = 13'((t / 8) * 80);
            next_y    = 3'(t % 8);
         end else if (stb) begin
            next_char = char_addr + 13'd1;
            next_y    = y_addr;
         end else begin
            next_char = 13'($urandom);
            next_y    = 3'($urandom);
         end
         if (in_rst) begin
            armed_m  = 1'b0;
            exp_char = 0;
            exp_y    = 0;
         end
         @(negedge clk_i);
         h_act   = (h >= 144) && (h <= 783);
         show    = !in_rst && armed_m && v_act && h_act;
         exp_pix = show ? glyph_bit(h, v) : 1'b0;
         exp_rgb = show ? (exp_pix ? 8'hFF : 8'h00) : 8'h00;
         check_val("pixel", 32'(pixel), 32'(exp_pix));
         check_val("rgb", 32'(rgb), 32'(exp_rgb));
         check_val("char_addr", 32'(char_addr), exp_char);
         check_val("y_addr", 32'(y_addr), exp_y);
         check_val("vram_addr", 32'(mem_if.vram_addr), exp_char);
         if (in_rst)
            check_val("font_addr_rst", 32'(mem_if.font_addr), 0);
         else if (armed_m && v_act && (h % 8 == 2) && (h >= 138) && (h <= 770))
            check_val("font_addr", 32'(mem_if.font_addr),
                      int'(vram_mem[exp_char]) * 8 + exp_y);
         if (!in_rst && stb && (armed_m || h == 136)) begin
            exp_char = (t / 8) * 80 + (h - 136) / 8;
            exp_y    = t % 8;
            armed_m  = 1'b1;
         end
      end
   endtask

   initial begin
      int blank_v [5] = '{515, 520, 524, 0, 34};
      n_checks  = 0;
      n_pass    = 0;
      armed_m   = 1'b0;
      exp_char  = 0;
      exp_y     = 0;
      rst_n_i   = 1'b0;
      h_count   = '0;
      v_count   = '0;
      next_char = '0;
      next_y    = '0;
      for (int i = 0; i < 8192; i++) vram_mem[i] = (i < 4800) ? 8'($urandom) : 8'h00;
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
      vram_mem[0]        = 8'h41;
      font_mem[8'h41 * 8] = 8'b1000_0001;
      vram_mem[79]       = 8'h42;
      font_mem[8'h42 * 8] = 8'hFF;

      run_line(20, 0, 9);
      run_line(35, -1, -1);
      run_line(36, 300, 304);
      run_line(37, -1, -1);
      run_line(38, -1, -1);
      run_line(43, -1, -1);
      repeat (10) run_line(35 + int'($urandom_range(0, 479)), -1, -1);
      run_line(514, -1, -1);
      check_val("char_end", 32'(char_addr), 4799);
      check_val("y_end", 32'(y_addr), 7);
      foreach (blank_v[i]) run_line(blank_v[i], -1, -1);
      check_val("char_hold", 32'(char_addr), 4799);
      check_val("y_hold", 32'(y_addr), 7);
      run_line(35, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
